// File: rtl/eblock_commit_sequencer.sv
// eblock_commit_sequencer
//   In-order commit ring for e-blocks that a scheduler dispatches and a CGRA
//   completes out of order. Entries retire from the head once they are done
//   or squashed. A mispredicted head retires with a flush pulse, and every
//   younger entry of the same CTA is squashed.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   dispatch_valid/ready/eblock_id/hw_cta_id/predicted   dispatch into the tail
//   done_valid/eblock_id/mispredict                      completion report, any order
//   commit_valid/ready/eblock_id/hw_cta_id/squashed      head retirement handshake
//   flush_valid, flush_hw_cta_id    one-cycle redirect pulse on a mispredicted commit
//   occupancy                       number of in-flight entries
//   id_error                        sticky: a completion matched no pending entry
module eblock_commit_sequencer #(
  parameter int unsigned MAX_NUM_CTA     = 4,
  parameter int unsigned MAX_EBLOCK      = 8,
  parameter int unsigned CTA_ID_WIDTH    = $clog2(MAX_NUM_CTA),
  parameter int unsigned EBLOCK_ID_WIDTH = $clog2(MAX_EBLOCK)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [EBLOCK_ID_WIDTH-1:0] dispatch_eblock_id,
  input  logic [CTA_ID_WIDTH-1:0]    dispatch_hw_cta_id,
  input  logic                       dispatch_predicted,
  input  logic                       done_valid,
  input  logic [EBLOCK_ID_WIDTH-1:0] done_eblock_id,
  input  logic                       done_mispredict,
  output logic                       commit_valid,
  output logic [EBLOCK_ID_WIDTH-1:0] commit_eblock_id,
  output logic [CTA_ID_WIDTH-1:0]    commit_hw_cta_id,
  output logic                       commit_squashed,
  input  logic                       commit_ready,
  output logic                       flush_valid,
  output logic [CTA_ID_WIDTH-1:0]    flush_hw_cta_id,
  output logic [EBLOCK_ID_WIDTH:0]   occupancy,
  output logic                       id_error
);

  localparam int unsigned PTR_W = (MAX_EBLOCK > 1) ? $clog2(MAX_EBLOCK) : 1;
  localparam int unsigned CNT_W = EBLOCK_ID_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_EBLOCK - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_EBLOCK);

  typedef struct packed {
    logic [EBLOCK_ID_WIDTH-1:0] eblock_id;
    logic [CTA_ID_WIDTH-1:0]    hw_cta_id;
    logic                       predicted;
    logic                       done;
    logic                       mispredict;
    logic                       squashed;
  } entry_t;

  entry_t                ring [MAX_EBLOCK];
  logic [MAX_EBLOCK-1:0] live;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  entry_t                head_ent;
  logic                  push;
  logic                  pop;
  logic [MAX_EBLOCK-1:0] done_hit;
  logic                  done_found;

  // Head view, handshakes and flush decision
  always_comb begin
    head_ent         = ring[head];
    dispatch_ready   = (count != FULL_CNT);
    occupancy        = count;
    commit_valid     = (count != '0) && (head_ent.done || head_ent.squashed);
    commit_eblock_id = head_ent.eblock_id;
    commit_hw_cta_id = head_ent.hw_cta_id;
    commit_squashed  = head_ent.squashed;
    push             = dispatch_valid && dispatch_ready;
    pop              = commit_valid && commit_ready;
    // A squashed entry never redirects, even if it carries a mispredict.
    flush_valid      = pop && head_ent.mispredict && !head_ent.squashed;
    flush_hw_cta_id  = head_ent.hw_cta_id;
  end

  // Completion lookup: first live, not-yet-done entry with the reported id
  always_comb begin
    done_hit   = '0;
    done_found = 1'b0;
    for (int i = 0; i < int'(MAX_EBLOCK); i++) begin
      if (!done_found && live[i] && !ring[i].done &&
          (ring[i].eblock_id == done_eblock_id)) begin
        done_hit[i] = done_valid;
        done_found  = 1'b1;
      end
    end
  end

  // Ring state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_EBLOCK); i++) begin
        ring[i] <= '0;
      end
      live     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      id_error <= 1'b0;
    end else begin
      for (int i = 0; i < int'(MAX_EBLOCK); i++) begin
        if (done_hit[i]) begin
          ring[i].done       <= 1'b1;
          ring[i].mispredict <= done_mispredict && ring[i].predicted;
        end
        // Every other live entry is younger than the head being flushed.
        if (flush_valid && live[i] && (PTR_W'(i) != head) &&
            (ring[i].hw_cta_id == head_ent.hw_cta_id)) begin
          ring[i].squashed <= 1'b1;
        end
      end

      if (done_valid && !done_found) begin
        id_error <= 1'b1;
      end

      if (pop) begin
        live[head] <= 1'b0;
        head       <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
      end

      // Tail slot is never live while dispatch_ready is high, so no write conflicts.
      if (push) begin
        ring[tail].eblock_id  <= dispatch_eblock_id;
        ring[tail].hw_cta_id  <= dispatch_hw_cta_id;
        ring[tail].predicted  <= dispatch_predicted;
        ring[tail].done       <= 1'b0;
        ring[tail].mispredict <= 1'b0;
        ring[tail].squashed   <= flush_valid && (dispatch_hw_cta_id == head_ent.hw_cta_id);
        live[tail]            <= 1'b1;
        tail                  <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_eblock_commit_sequencer.sv
module tb_eblock_commit_sequencer;

  localparam int unsigned NCTA = 4;
  localparam int unsigned NEB  = 8;
  localparam int unsigned CW   = 2;
  localparam int unsigned EW   = 3;

  logic          clk;
  logic          rst_n;
  logic          dispatch_valid;
  logic          dispatch_ready;
  logic [EW-1:0] dispatch_eblock_id;
  logic [CW-1:0] dispatch_hw_cta_id;
  logic          dispatch_predicted;
  logic          done_valid;
  logic [EW-1:0] done_eblock_id;
  logic          done_mispredict;
  logic          commit_valid;
  logic [EW-1:0] commit_eblock_id;
  logic [CW-1:0] commit_hw_cta_id;
  logic          commit_squashed;
  logic          commit_ready;
  logic          flush_valid;
  logic [CW-1:0] flush_hw_cta_id;
  logic [EW:0]   occupancy;
  logic          id_error;

  eblock_commit_sequencer #(
    .MAX_NUM_CTA(NCTA), .MAX_EBLOCK(NEB), .CTA_ID_WIDTH(CW), .EBLOCK_ID_WIDTH(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_eblock_id(dispatch_eblock_id), .dispatch_hw_cta_id(dispatch_hw_cta_id),
    .dispatch_predicted(dispatch_predicted),
    .done_valid(done_valid), .done_eblock_id(done_eblock_id), .done_mispredict(done_mispredict),
    .commit_valid(commit_valid), .commit_eblock_id(commit_eblock_id),
    .commit_hw_cta_id(commit_hw_cta_id), .commit_squashed(commit_squashed),
    .commit_ready(commit_ready),
    .flush_valid(flush_valid), .flush_hw_cta_id(flush_hw_cta_id),
    .occupancy(occupancy), .id_error(id_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected retirement record, queued in dispatch order
  typedef struct {
    logic [EW-1:0] id;
    logic [CW-1:0] cta;
    logic          sq;
    logic          fl;
  } exp_t;

  // One cycle of the in-order scenario: inputs plus outputs expected before the edge
  typedef struct {
    logic          dv;
    logic [EW-1:0] did;
    logic          dnv;
    logic [EW-1:0] dnid;
    logic          exp_cv;
    logic [EW-1:0] exp_cid;
    int            exp_occ;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[9];
  int   checks   = 0;
  int   failures = 0;
  logic exp_sq;
  logic exp_fl;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid     = 1'b0;
    dispatch_eblock_id = '0;
    dispatch_hw_cta_id = '0;
    dispatch_predicted = 1'b0;
    done_valid         = 1'b0;
    done_eblock_id     = '0;
    done_mispredict    = 1'b0;
    exp_sq             = 1'b0;
    exp_fl             = 1'b0;
  endtask

  task automatic disp(input int id, input int cta, input logic pred, input logic sq, input logic fl);
    dispatch_valid     = 1'b1;
    dispatch_eblock_id = EW'(id);
    dispatch_hw_cta_id = CW'(cta);
    dispatch_predicted = pred;
    exp_sq             = sq;
    exp_fl             = fl;
  endtask

  task automatic done(input int id, input logic mis);
    done_valid      = 1'b1;
    done_eblock_id  = EW'(id);
    done_mispredict = mis;
  endtask

  // Scoreboard: record accepted dispatches, compare every retirement
  always @(negedge clk) begin
    if (rst_n) begin
      if (dispatch_valid && dispatch_ready) begin
        mon_e.id  = dispatch_eblock_id;
        mon_e.cta = dispatch_hw_cta_id;
        mon_e.sq  = exp_sq;
        mon_e.fl  = exp_fl;
        sb.push_back(mon_e);
      end
      if (commit_valid && commit_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit actual_id=%0d required=none (t=%0t)", commit_eblock_id, $time);
        end else begin
          mon_e = sb.pop_front();
          check("commit_id", int'(commit_eblock_id), int'(mon_e.id));
          check("commit_cta", int'(commit_hw_cta_id), int'(mon_e.cta));
          check("commit_squashed", int'(commit_squashed), int'(mon_e.sq));
          check("flush_valid", int'(flush_valid), int'(mon_e.fl));
          if (mon_e.fl) check("flush_cta", int'(flush_hw_cta_id), int'(mon_e.cta));
        end
      end else if (flush_valid) begin
        checks++;
        failures++;
        $display("FAIL flush_without_pop actual=1 required=0 (t=%0t)", $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // In-order commits from out-of-order completions: ids 0,1,2 done as 2,0,1
    vt[0] = '{1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 0};
    vt[1] = '{1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 1};
    vt[2] = '{1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 2};
    vt[3] = '{1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 3};
    vt[4] = '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 3};
    vt[5] = '{1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 3'd0, 3};
    vt[6] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 2};
    vt[7] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1};
    vt[8] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 0};

    idle();
    commit_ready = 1'b0;
    rst_n        = 1'b0;
    #3;
    check("rst_commit_valid", int'(commit_valid), 0);
    check("rst_flush_valid", int'(flush_valid), 0);
    check("rst_dispatch_ready", int'(dispatch_ready), 1);
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_id_error", int'(id_error), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    commit_ready = 1'b1;
    tick();

    // Table-driven in-order scenario
    for (int i = 0; i < 9; i++) begin
      idle();
      if (vt[i].dv) disp(int'(vt[i].did), 0, 1'b0, 1'b0, 1'b0);
      if (vt[i].dnv) done(int'(vt[i].dnid), 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_commit_valid", i), int'(commit_valid), int'(vt[i].exp_cv));
      if (vt[i].exp_cv) check($sformatf("vec%0d_commit_id", i), int'(commit_eblock_id), int'(vt[i].exp_cid));
      check($sformatf("vec%0d_occupancy", i), int'(occupancy), vt[i].exp_occ);
      check($sformatf("vec%0d_dispatch_ready", i), int'(dispatch_ready), 1);
      tick();
    end

    // Fill to capacity across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      idle();
      disp(i, 0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    @(negedge clk);
    check("full_dispatch_ready", int'(dispatch_ready), 0);
    check("full_occupancy", int'(occupancy), 8);
    tick();
    disp(0, 1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("full_blocked_occupancy", int'(occupancy), 8);
    done(0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("full_pop_commit_valid", int'(commit_valid), 1);
    check("full_pop_dispatch_ready", int'(dispatch_ready), 0);
    tick();
    @(negedge clk);
    check("after_pop_dispatch_ready", int'(dispatch_ready), 1);
    check("after_pop_occupancy", int'(occupancy), 7);
    tick();
    for (int i = 1; i < 8; i++) begin
      idle();
      done(i, 1'b0);
      tick();
    end
    idle();
    for (int k = 0; k < 30 && occupancy != 0; k++) tick();
    check("drain_occupancy", int'(occupancy), 0);

    // Mispredict flush, squash of younger same-CTA entries, same-cycle dispatch
    disp(3, 1, 1'b1, 1'b0, 1'b1); tick();
    disp(4, 1, 1'b0, 1'b1, 1'b0); tick();
    disp(5, 2, 1'b0, 1'b0, 1'b0); tick();
    idle(); done(3, 1'b1); tick();
    idle(); disp(6, 1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("mp_commit_valid", int'(commit_valid), 1);
    check("mp_commit_id", int'(commit_eblock_id), 3);
    check("mp_flush_valid", int'(flush_valid), 1);
    check("mp_flush_cta", int'(flush_hw_cta_id), 1);
    check("mp_occupancy", int'(occupancy), 3);
    tick();
    idle();
    @(negedge clk);
    check("sq_commit_valid", int'(commit_valid), 1);
    check("sq_commit_id", int'(commit_eblock_id), 4);
    check("sq_commit_squashed", int'(commit_squashed), 1);
    check("sq_flush_valid", int'(flush_valid), 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("wait_own_done_commit_valid", int'(commit_valid), 0);
      tick();
    end
    done(5, 1'b0); tick();
    idle();
    @(negedge clk);
    check("own_done_commit_id", int'(commit_eblock_id), 5);
    tick();
    @(negedge clk);
    check("same_cycle_disp_squashed", int'(commit_squashed), 1);
    check("same_cycle_disp_id", int'(commit_eblock_id), 6);
    tick();
    @(negedge clk);
    check("mp_drain_occupancy", int'(occupancy), 0);
    // Mispredict on a non-predicted entry does not redirect
    disp(0, 3, 1'b0, 1'b0, 1'b0); tick();
    idle(); done(0, 1'b1); tick();
    idle();
    @(negedge clk);
    check("unpred_commit_valid", int'(commit_valid), 1);
    check("unpred_flush_valid", int'(flush_valid), 0);
    tick();

    // Back-pressure holds the head stable
    commit_ready = 1'b0;
    disp(1, 2, 1'b0, 1'b0, 1'b0); tick();
    idle(); done(1, 1'b0); tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_commit_valid", int'(commit_valid), 1);
      check("hold_commit_id", int'(commit_eblock_id), 1);
      check("hold_occupancy", int'(occupancy), 1);
      tick();
    end
    commit_ready = 1'b1;
    tick();
    @(negedge clk);
    check("hold_release_commit_valid", int'(commit_valid), 0);
    check("hold_release_occupancy", int'(occupancy), 0);
    tick();

    // Completion for an id not in flight
    @(negedge clk);
    check("pre_err_id_error", int'(id_error), 0);
    done(6, 1'b0); tick();
    idle();
    repeat (3) tick();
    @(negedge clk);
    check("err_id_error", int'(id_error), 1);
    check("err_occupancy", int'(occupancy), 0);
    check("err_commit_valid", int'(commit_valid), 0);
    tick();

    // Reset with five entries in flight
    commit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(); disp(i, 0, 1'b0, 1'b0, 1'b0); tick();
    end
    idle(); done(0, 1'b0); tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_occupancy", int'(occupancy), 0);
    check("mid_rst_commit_valid", int'(commit_valid), 0);
    check("mid_rst_dispatch_ready", int'(dispatch_ready), 1);
    check("mid_rst_id_error", int'(id_error), 0);
    sb.delete();
    tick();
    rst_n        = 1'b1;
    commit_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_commit_valid", int'(commit_valid), 0);
      tick();
    end

    // Second completion for an already-done entry
    commit_ready = 1'b0;
    disp(2, 3, 1'b0, 1'b0, 1'b0); tick();
    idle(); done(2, 1'b0); tick();
    idle();
    @(negedge clk);
    check("dup_pre_id_error", int'(id_error), 0);
    done(2, 1'b0); tick();
    idle();
    @(negedge clk);
    check("dup_id_error", int'(id_error), 1);
    check("dup_commit_id", int'(commit_eblock_id), 2);
    check("dup_occupancy", int'(occupancy), 1);
    commit_ready = 1'b1;
    tick();
    @(negedge clk);
    check("dup_drain_occupancy", int'(occupancy), 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
